calculator_core_seq: RTL
========================

// Module: calculator_core_seq
// PURPOSE
//  Sequencing core of the calculator: accepts keypad codes, builds operands in a parametrised radix,
//  issues one ALU request per operation, and pushes every value change to the display driver.
//  Supports chained operations, negate, clear and a sticky error state.
//  Sits between the button debouncer/encoder and the ALU/display blocks.
// PARAMETERS
//  DATA_WIDTH  16  operand/result width in bits
//  RADIX       10  entry radix, legal 2..16; digit codes >= RADIX are ignored
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   asynchronous reset, active-high
//  i_button_data       in   5   0-15 digit, 16 ADD, 17 SUB, 18 MUL, 19 DIV, 20 EQ, 21 CLR, 22 NEG, others ignored
//  i_button_valid      in   1   button code valid
//  o_button_ready      out  1   core can accept a button this cycle
//  i_2s_comp_mode      in   1   1: signed mode (NEG allowed, signed ALU, signed display)
//  o_alu_input_a/b     out  DW  operands A, B
//  o_alu_input_op      out  2   00 ADD, 01 SUB, 10 MUL, 11 DIV
//  o_alu_input_signed  out  1   i_2s_comp_mode sampled when the request is issued
//  o_alu_input_valid   out  1   ALU request valid
//  i_alu_input_ready   in   1   ALU accepts request
//  i_alu_result        in   DW  ALU result
//  i_alu_error         in   1   result invalid (e.g. divide by zero); qualified by result_valid
//  i_alu_result_valid  in   1   ALU result valid
//  o_alu_result_ready  out  1   core accepts result
//  o_add/sub/mul/div_state_display out 1 each  one-hot pending operator, else 0
//  o_error             out  1   sticky error indicator
//  o_display_data      out  DW  value to show
//  o_display_2s_comp   out  1   display o_display_data as signed
//  o_display_valid     out  1   display request valid
//  i_display_ready     in   1   display accepts request
//  i_display_done      in   1   single-cycle pulse: display finished drawing
// BEHAVIOUR
//  Reset: all outputs 0 except o_button_ready=0 (goes 1 after the reset display completes);
//   regs A=B=0; op=ADD; state DISP_REQ with data 0 (display cleared on reset exit).
//  States: ENTER_A, OP_SEL, ENTER_B, RESULT, ALU_REQ, ALU_WAIT, DISP_REQ, DISP_WAIT, ERROR.
//  o_button_ready=1 only in ENTER_A, OP_SEL, ENTER_B, RESULT, ERROR. Button accepted on valid&&ready.
//  Digit d<RADIX: ENTER_A/ENTER_B: acc = (acc*RADIX + d) mod 2^DW (wraps, no saturation).
//   OP_SEL: B=d -> ENTER_B. RESULT: A=d -> ENTER_A. ERROR: ignored.
//  Op: ENTER_A/RESULT: latch op -> OP_SEL. OP_SEL: replace op. ENTER_B: issue A op B, then latch
//   new op, result->A, go OP_SEL (chaining). ERROR: ignored.
//  EQ: ENTER_B: issue A op B, result->A, go RESULT. Otherwise ignored (no display update).
//  NEG: only if i_2s_comp_mode; negates entry in ENTER_A/ENTER_B/RESULT (acc = -acc mod 2^DW); else ignored.
//  CLR: from any button-ready state incl. ERROR: A=B=0, op=ADD, o_error=0 -> display 0 -> ENTER_A.
//  Every accepted button that changes A, B, op or error goes through DISP_REQ; ignored buttons do not.
//  Displayed value: B in ENTER_B (and OP_SEL shows A), else A; o_display_2s_comp = i_2s_comp_mode.
//  ALU_REQ: o_alu_input_valid=1, operands stable until valid&&ready; then ALU_WAIT, o_alu_result_ready=1.
//  ALU_WAIT: on result_valid: error=0 -> A=result, B=0; error=1 -> o_error=1, display 0, next ERROR.
//  DISP_REQ: o_display_valid=1 until valid&&ready -> DISP_WAIT; wait i_display_done -> target state.
//   A done pulse arriving in the same cycle as the handshake counts.
//  Latency: button accepted cycle N -> o_display_valid at N+1 (non-ALU);
//   ALU result accepted cycle M -> o_display_valid at M+1.
//  Operator one-hot outputs asserted in OP_SEL/ENTER_B for the latched op, and held during ALU/display
//   of a chained op (new op shown).
//  Reset mid-operation: all state aborted immediately, pending ALU/display requests dropped.
//  i_2s_comp_mode change mid-entry: affects only future requests/displays; stored bits unchanged.
// TESTING
//  Reset; keys 1,2,3 (RADIX10) -> displays 1,12,123; A=123, ready low between key and display_done.
//  12 ADD 30 EQ, ALU returns 42 -> ALU a=12 b=30 op=00; display 42; state RESULT; add_state cleared.
//  Chain 5 MUL 4 SUB (ALU 20) 3 EQ -> second request a=20 b=3 op=01; sub_state high after first result.
//  9 DIV 0 EQ with i_alu_error=1 -> o_error=1, display 0; digits/ops ignored; CLR -> o_error=0, display 0.
//  DW=8, 2s-comp: 2,5,6 -> wraps 256 mod 256=0; NEG on 5 -> 0xFB displayed signed; NEG in unsigned ignored.
//  ALU ready held low 10 cycles, display ready delayed -> operands stable, no button accepted until done.

Source files
------------

// File: rtl/calculator_core_seq.sv
// calculator_core_seq: keypad sequencer that builds operands, issues ALU requests and
// pushes every value change to the display driver.
module calculator_core_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int RADIX      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            i_button_data,
    input  logic                  i_button_valid,
    output logic                  o_button_ready,
    input  logic                  i_2s_comp_mode,
    output logic [DATA_WIDTH-1:0] o_alu_input_a,
    output logic [DATA_WIDTH-1:0] o_alu_input_b,
    output logic [1:0]            o_alu_input_op,
    output logic                  o_alu_input_signed,
    output logic                  o_alu_input_valid,
    input  logic                  i_alu_input_ready,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_alu_error,
    input  logic                  i_alu_result_valid,
    output logic                  o_alu_result_ready,
    output logic                  o_add_state_display,
    output logic                  o_sub_state_display,
    output logic                  o_mul_state_display,
    output logic                  o_div_state_display,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_display_data,
    output logic                  o_display_2s_comp,
    output logic                  o_display_valid,
    input  logic                  i_display_ready,
    input  logic                  i_display_done
);
    typedef enum logic [3:0] {
        ENTER_A, OP_SEL, ENTER_B, RESULT, ALU_REQ, ALU_WAIT, DISP_REQ, DISP_WAIT, ERROR
    } state_t;
    localparam logic [4:0] EQ = 5'd20;
    localparam logic [4:0] CLR = 5'd21;
    localparam logic [4:0] NEG = 5'd22;
    localparam logic [DATA_WIDTH-1:0] RAD = DATA_WIDTH'(RADIX);
    state_t state, state_n, target, target_n;
    logic [DATA_WIDTH-1:0] a, a_n, b, b_n, disp, disp_n, dig, acc, acc_dig;
    logic [1:0] op, op_n, alu_op, alu_op_n;
    logic err, err_n, alu_sgn, alu_sgn_n, disp_sgn, disp_sgn_n, live, upd;
    logic take, is_dig, is_op, show;

    assign o_button_ready = state inside {ENTER_A, OP_SEL, ENTER_B, RESULT, ERROR};
    assign take = i_button_valid && o_button_ready;
    assign is_dig = i_button_data < 5'(RADIX);
    assign is_op = i_button_data[4:2] == 3'b100;
    assign dig = DATA_WIDTH'(i_button_data[3:0]);
    assign acc = state == ENTER_B ? b : a;
    assign acc_dig = acc * RAD + dig;
    // a chained op keeps its new operator lit while the ALU and display round trip runs
    assign show = state inside {OP_SEL, ENTER_B} || (!o_button_ready && target inside {OP_SEL, ENTER_B});
    assign o_add_state_display = show && op == 2'd0;
    assign o_sub_state_display = show && op == 2'd1;
    assign o_mul_state_display = show && op == 2'd2;
    assign o_div_state_display = show && op == 2'd3;
    assign o_alu_input_a = a;
    assign o_alu_input_b = b;
    assign o_alu_input_op = alu_op;
    assign o_alu_input_signed = alu_sgn;
    assign o_alu_input_valid = state == ALU_REQ;
    assign o_alu_result_ready = state == ALU_WAIT;
    assign o_error = err;
    assign o_display_data = disp;
    assign o_display_2s_comp = disp_sgn;
    assign o_display_valid = state == DISP_REQ && live;

    always_comb begin
        state_n = state;
        target_n = target;
        a_n = a;
        b_n = b;
        op_n = op;
        alu_op_n = alu_op;
        err_n = err;
        alu_sgn_n = alu_sgn;
        disp_n = disp;
        disp_sgn_n = disp_sgn;
        upd = 1'b0;
        case (state)
            ALU_REQ: state_n = i_alu_input_ready ? ALU_WAIT : ALU_REQ;
            ALU_WAIT: if (i_alu_result_valid) begin
                state_n = DISP_REQ;
                disp_sgn_n = i_2s_comp_mode;
                if (i_alu_error) begin
                    err_n = 1'b1;
                    disp_n = '0;
                    target_n = ERROR;
                end else begin
                    a_n = i_alu_result;
                    b_n = '0;
                    disp_n = i_alu_result;
                end
            end
            DISP_REQ: if (live && i_display_ready) state_n = i_display_done ? target : DISP_WAIT;
            DISP_WAIT: if (i_display_done) state_n = target;
            default: if (take) begin
                upd = 1'b1;
                if (i_button_data == CLR) begin
                    a_n = '0;
                    b_n = '0;
                    op_n = 2'd0;
                    err_n = 1'b0;
                    target_n = ENTER_A;
                end else if (state == ERROR) begin
                    upd = 1'b0;
                end else if (is_dig) begin
                    a_n = state == ENTER_A ? acc_dig : state == RESULT ? dig : a;
                    b_n = state == ENTER_B ? acc_dig : state == OP_SEL ? dig : b;
                    target_n = state inside {OP_SEL, ENTER_B} ? ENTER_B : ENTER_A;
                end else if ((is_op || i_button_data == EQ) && state == ENTER_B) begin
                    upd = 1'b0;
                    alu_op_n = op;
                    alu_sgn_n = i_2s_comp_mode;
                    op_n = is_op ? i_button_data[1:0] : op;
                    target_n = is_op ? OP_SEL : RESULT;
                    state_n = ALU_REQ;
                end else if (is_op) begin
                    op_n = i_button_data[1:0];
                    target_n = OP_SEL;
                end else if (i_button_data == NEG && i_2s_comp_mode && state != OP_SEL) begin
                    a_n = state == ENTER_B ? a : -a;
                    b_n = state == ENTER_B ? -b : b;
                    target_n = state;
                end else begin
                    upd = 1'b0;
                end
            end
        endcase
        if (upd) begin
            state_n = DISP_REQ;
            disp_n = target_n == ENTER_B ? b_n : a_n;
            disp_sgn_n = i_2s_comp_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DISP_REQ;
            target <= ENTER_A;
            a <= '0;
            b <= '0;
            op <= 2'd0;
            alu_op <= 2'd0;
            err <= 1'b0;
            alu_sgn <= 1'b0;
            disp <= '0;
            disp_sgn <= 1'b0;
            live <= 1'b0;
        end else begin
            state <= state_n;
            target <= target_n;
            a <= a_n;
            b <= b_n;
            op <= op_n;
            alu_op <= alu_op_n;
            err <= err_n;
            alu_sgn <= alu_sgn_n;
            disp <= disp_n;
            disp_sgn <= disp_sgn_n;
            live <= 1'b1;
        end
    end
endmodule
